mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Multi-cycle main-memory arbiter for the 16-bit pipelined CPU. It shares the single main-memory port between the instruction-cache miss fill, the data-cache miss fill and data-side write-through stores. It sequences 8-word block fills and single-word writes, drives the per-side stall signals into the pipeline stall logic, and steers returning words into the correct cache's fill port.

## Interface
Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_miss  in  1  I-cache miss level; held until `i_done`.
- i_addr  in  ADDR_W  I-side miss address; only bits [15:4] are used.
- d_miss  in  1  D-cache miss level; held until `d_done`.
- d_wr  in  1  D-side write-through store level; held until `d_done`.
- d_addr  in  ADDR_W  D-side miss or store address.
- d_wdata  in  DATA_W  store data.
- mem_en  out  1  memory request strobe; one word per cycle.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory word address, always even.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  read data valid; fixed latency after issue, in order.
- fill_data  out  DATA_W  `mem_rdata` passed through.
- fill_word  out  3  word index within the block.
- fill_i_we  out  1  I-cache fill write enable.
- fill_d_we  out  1  D-cache fill write enable.
- i_done  out  1  one-cycle pulse: I fill complete.
- d_done  out  1  one-cycle pulse: D fill or write complete.
- i_stall  out  1  I-side waiting.
- d_stall  out  1  D-side waiting.

## Operation
- **FSM states:** IDLE, FILL_I, FILL_D, WRITE.
- **Arbitration in IDLE**, sampled at the clock edge, first match wins:
  - `d_miss` → FILL_D.
  - `d_wr` → WRITE.
  - `i_miss` → FILL_I.
  - D-side has strict priority because the MEM-stage instruction is older. `d_miss` and `d_wr` both high is illegal; `d_miss` wins.
- **Grant latch:** on grant, latch `blk = addr[15:4]` (or the full `d_addr` and `d_wdata` for WRITE). Later input changes are ignored until the FSM returns to IDLE.
- **FILL_x:**
  - Issue counter `icnt` runs 0..7; one read per cycle with `mem_en=1`, `mem_wr=0`, `mem_addr={blk,icnt,1'b0}`.
  - Issue stops after `icnt=7`.
  - Receive counter `rcnt` increments on each `mem_rvalid`. In that cycle: `fill_word=rcnt`, and `fill_x_we=1` on the granted side only.
  - The `mem_rvalid` with `rcnt=7` also asserts `x_done`. The FSM then goes to IDLE and both counters clear.
- **WRITE:** lasts exactly one cycle with `mem_en=1`, `mem_wr=1`, latched address and data, and `d_done=1`; then the FSM goes to IDLE.
- **Stalls (combinational):**
  - `i_stall = i_miss & ~i_done`.
  - `d_stall = (d_miss | d_wr) & ~d_done`.
- **Stray `mem_rvalid`** in IDLE or WRITE is ignored: no fill write enable, no counter change.
- **Reset value of every output is 0:** state IDLE, counters 0, latches 0; all strobes, write enables and done pulses low; stalls follow their inputs.
- **Reset mid-fill:** the FSM returns to IDLE immediately and the partial block is abandoned. The memory shares `rst`, which flushes its in-flight reads.
- **Requester obligation:** deassert the request the cycle after `done`, since the cache now hits. A request still high in IDLE is re-granted.

## Timing
- Request seen high before edge 0 → granted state in cycle 1.
- A fill issues in cycles 1..8. With memory latency L, data returns in cycles 1+L..8+L and `done` is in cycle 8+L. IDLE is in cycle 9+L, and a pending request is granted for cycle 10+L.
- For L=4, `done` is in cycle 12.
- WRITE: grant → `mem_en` and `d_done` in cycle 1 → IDLE in cycle 2.
- There is no back-to-back grant without one IDLE cycle.
- Issue and receive overlap whenever L < 8; the counters are independent.

## Structure
- **Shared CPU package:**
  - state encoding: IDLE=2'b00, FILL_I=2'b01, FILL_D=2'b10, WRITE=2'b11.
  - BLOCK_WORDS=8.
  - BLK_OFF_W=4 (block offset bits).
- **Sub-module `word_cnt3`:** 3-bit counter built from the team `dff` cells, with synchronous clear and increment enable. It is instantiated twice, for `icnt` and `rcnt`.
- State and latches use `dff` cells with `wen` tied to the grant condition.

## Test plan
- **I fill:** `i_miss=1`, `i_addr=16'h1234`, L=4 → reads 16'h1230..16'h123E in cycles 1..8; `fill_i_we` with `fill_word` 0..7 in cycles 5..12; `i_done` in cycle 12; `i_stall` high in cycles 0..11.
- **Simultaneous requests:** `i_miss` and `d_miss` both high, `d_addr=16'h8010` → D fill first (addresses 16'h8010..16'h801E, `d_done` in cycle 12); I granted in cycle 14; `i_stall` high throughout.
- **Write through:** `d_wr=1`, `d_addr=16'h00A2`, `d_wdata=16'hBEEF` → cycle 1: `mem_en=1`, `mem_wr=1`, `mem_addr=16'h00A2`, `mem_wdata=16'hBEEF`, `d_done=1`; IDLE in cycle 2.
- **Stray data:** `mem_rvalid` pulsed in IDLE → no `fill_*_we`; the next fill still starts at `fill_word=0`.
- **Reset mid-fill:** `rst` in cycle 6 of an I fill → cycle 7 in IDLE, all outputs 0; a new `d_miss` yields a complete fill with `fill_word` 0..7.
- **Held request:** `i_miss` held one cycle past `i_done` → re-granted; checks the documented requester obligation.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and block geometry for the main-memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FILL_I = 2'b01,
        FILL_D = 2'b10,
        WRITE  = 2'b11
    } state_t;
    localparam int BLOCK_WORDS = 8;
    localparam int BLK_OFF_W   = 4;
endpackage

// File: rtl/dff.sv
// dff: team enable flop with synchronous active-high clear
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // capture d when enabled; reset clears to zero
    always_ff @(posedge clk) q <= rst ? '0 : wen ? d : q;
endmodule

// File: rtl/mem_arbiter_word_cnt3.sv
// word_cnt3: 3-bit word counter with synchronous clear and increment enable
module word_cnt3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] q
);
    logic [2:0] cnt_d;
    // clear wins over increment
    always_comb cnt_d = clr ? 3'd0 : q + 3'd1;
    dff #(.W(3)) u_cnt (.clk(clk), .rst(rst), .wen(clr | inc), .d(cnt_d), .q(q));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I fill, D fill and D write-through
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              fill_i_we,
    output logic              fill_d_we,
    output logic              i_done,
    output logic              d_done,
    output logic              i_stall,
    output logic              d_stall
);
    logic [1:0]        state_q;
    state_t            state_d, st;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic              issued_q, issued_d;
    logic [2:0]        icnt, rcnt;
    logic              d_req, grant, fill_i, fill_d, filling, writing, issuing, last_rx;
    logic              unused_ok;

    assign st        = state_t'(state_q);
    assign d_req     = d_miss | d_wr;
    assign grant     = (st == IDLE) && (d_req || i_miss);
    assign fill_i    = st == FILL_I;
    assign fill_d    = st == FILL_D;
    assign filling   = fill_i || fill_d;
    assign writing   = st == WRITE;
    assign issuing   = filling && !issued_q;
    assign last_rx   = filling && mem_rvalid && rcnt == 3'(BLOCK_WORDS - 1);
    assign unused_ok = ^{i_addr[0], d_addr[0]};

    // next state (D side first), grant latch source and the all-words-issued flag
    always_comb begin
        state_d  = (st == IDLE) ? (d_miss ? FILL_D : d_wr ? WRITE : i_miss ? FILL_I : IDLE)
                 : (writing || last_rx) ? IDLE : st;
        addr_d   = d_req ? d_addr[ADDR_W-1:1] : i_addr[ADDR_W-1:1];
        issued_d = last_rx ? 1'b0 : (issuing && icnt == 3'(BLOCK_WORDS - 1)) ? 1'b1 : issued_q;
    end

    dff #(.W(2))        u_state  (.clk(clk), .rst(rst), .wen(1'b1),  .d(state_d),  .q(state_q));
    dff #(.W(ADDR_W-1)) u_addr   (.clk(clk), .rst(rst), .wen(grant), .d(addr_d),   .q(addr_q));
    dff #(.W(DATA_W))   u_wdata  (.clk(clk), .rst(rst), .wen(grant), .d(d_wdata),  .q(wdata_q));
    dff #(.W(1))        u_issued (.clk(clk), .rst(rst), .wen(1'b1),  .d(issued_d), .q(issued_q));

    word_cnt3 u_icnt (.clk(clk), .rst(rst), .clr(last_rx), .inc(issuing),              .q(icnt));
    word_cnt3 u_rcnt (.clk(clk), .rst(rst), .clr(last_rx), .inc(filling && mem_rvalid), .q(rcnt));

    assign mem_en    = issuing || writing;
    assign mem_wr    = writing;
    assign mem_addr  = writing ? {addr_q, 1'b0}
                     : issuing ? {addr_q[ADDR_W-2:BLK_OFF_W-1], icnt, 1'b0} : '0;
    assign mem_wdata = writing ? wdata_q : '0;
    assign fill_data = mem_rdata;
    assign fill_word = rcnt;
    assign fill_i_we = fill_i && mem_rvalid;
    assign fill_d_we = fill_d && mem_rvalid;
    assign i_done    = fill_i && last_rx;
    assign d_done    = (fill_d && last_rx) || writing;
    assign i_stall   = i_miss & ~i_done;
    assign d_stall   = d_req & ~d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory checked against a transaction schedule model
module tb_mem_arbiter;
    localparam int L     = 4;
    localparam int NCYC  = 3000;
    localparam int DEPTH = 4096;

    typedef struct {
        bit        en, wr, iwe, dwe, idone, ddone;
        bit [2:0]  word;
        bit [15:0] addr, wdata, fdata;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_word;
    logic        fill_i_we, fill_d_we, i_done, d_done, i_stall, d_stall;

    int          cyc = 0, n_chk = 0, n_err = 0;
    int          c, g, free_at = 0, fe = -1;
    bit          i_hold = 1'b0, sd;
    logic [15:0] a, base;
    exp_t        ex [DEPTH];

    logic [L-1:0] pv = '0;
    logic [15:0]  pa [L];
    logic         stray_q = 1'b0, stray_n = 1'b0;
    logic [15:0]  stray_dq = '0, stray_dn = '0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .fill_data(fill_data),
        .fill_word(fill_word), .fill_i_we(fill_i_we), .fill_d_we(fill_d_we), .i_done(i_done),
        .d_done(d_done), .i_stall(i_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(input logic [15:0] x);
        return (x * 16'd40503) ^ 16'h5A3C;
    endfunction

    // memory: fixed latency L, in order, flushed by rst; plus stray valid pulses
    always @(posedge clk) begin
        pv <= rst ? '0 : {pv[L-2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
        stray_q  <= stray_n;
        stray_dq <= stray_dn;
    end
    assign mem_rvalid = pv[L-1] | stray_q;
    assign mem_rdata  = pv[L-1] ? memf(pa[L-1]) : stray_q ? stray_dq : '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) ex[k] = '{default: 0};
        repeat (NCYC) begin
            @(negedge clk);
            c = cyc;
            chk("mem_en", mem_en, ex[c].en);
            chk("mem_wr", mem_wr, ex[c].wr);
            chk("mem_addr", mem_addr, ex[c].addr);
            chk("mem_wdata", mem_wdata, ex[c].wdata);
            chk("fill_i_we", fill_i_we, ex[c].iwe);
            chk("fill_d_we", fill_d_we, ex[c].dwe);
            chk("i_done", i_done, ex[c].idone);
            chk("d_done", d_done, ex[c].ddone);
            chk("i_stall", i_stall, i_miss & ~ex[c].idone);
            chk("d_stall", d_stall, (d_miss | d_wr) & ~ex[c].ddone);
            if (ex[c].iwe || ex[c].dwe) begin
                chk("fill_word", fill_word, ex[c].word);
                chk("fill_data", fill_data, ex[c].fdata);
            end
            // requesters: hold until done, drop after (sometimes one cycle late)
            if (i_hold) begin
                i_miss = 1'b0;
                i_hold = 1'b0;
            end else if (ex[c].idone) begin
                if ($urandom_range(0, 3) == 0) i_hold = 1'b1;
                else i_miss = 1'b0;
            end else if (c > 3 && !i_miss && $urandom_range(0, 3) == 0) begin
                i_miss = 1'b1;
                i_addr = 16'($urandom);
            end
            if (ex[c].ddone) begin
                d_miss = 1'b0;
                d_wr   = 1'b0;
            end else if (c > 3 && !d_miss && !d_wr && $urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) d_miss = 1'b1;
                else d_wr = 1'b1;
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            if (c > 3 && $urandom_range(0, 7) == 0) i_addr = 16'($urandom);
            if (c > 3 && $urandom_range(0, 7) == 0) d_addr = 16'($urandom);
            if (c > 3 && $urandom_range(0, 7) == 0) d_wdata = 16'($urandom);
            if (c == 3) begin
                i_miss = 1'b1;
                i_addr = 16'h1234;
                d_miss = 1'b1;
                d_addr = 16'h8010;
            end
            rst = (c < 3) || ($urandom_range(0, 249) == 0);
            // reference schedule: what each granted transaction must produce, by cycle
            if (rst) begin
                for (int k = c + 1; k < c + 24; k++) ex[k] = '{default: 0};
                free_at = c + 1;
                fe = -1;
            end else if (c >= free_at && (d_miss || d_wr || i_miss)) begin
                g = c + 1;
                if (d_wr && !d_miss) begin
                    ex[g].en    = 1'b1;
                    ex[g].wr    = 1'b1;
                    ex[g].addr  = d_addr & 16'hFFFE;
                    ex[g].wdata = d_wdata;
                    ex[g].ddone = 1'b1;
                    free_at = g + 1;
                end else begin
                    sd   = d_miss;
                    a    = sd ? d_addr : i_addr;
                    base = a & 16'hFFF0;
                    for (int k = 0; k < 8; k++) begin
                        ex[g+k].en       = 1'b1;
                        ex[g+k].addr     = base + 16'(2 * k);
                        ex[g+L+k].iwe    = !sd;
                        ex[g+L+k].dwe    = sd;
                        ex[g+L+k].word   = 3'(k);
                        ex[g+L+k].fdata  = memf(base + 16'(2 * k));
                    end
                    if (sd) ex[g+7+L].ddone = 1'b1;
                    else ex[g+7+L].idone = 1'b1;
                    fe = g + 7 + L;
                    free_at = g + 8 + L;
                end
            end
            stray_n  = (c + 1 > fe) && ($urandom_range(0, 4) == 0);
            stray_dn = 16'($urandom);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
